// File: rtl/game_core_nxn_if.sv
// rtl/game_core_nxn_if.sv - bus bundle between cell-decode logic, game core and VGA painter
interface game_core_nxn_if #(
  parameter int N       = 3,
  parameter int SCORE_W = 4
);
  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);

  logic                 start;
  logic                 cell_valid;
  logic [IDX_W-1:0]     cell_idx;
  logic                 restart;
  logic                 clear_scores;
  logic [CELLS-1:0]     board_x;
  logic [CELLS-1:0]     board_o;
  logic                 turn_x;
  logic                 move_ack;
  logic                 move_nack;
  logic                 busy;
  logic [CELLS-1:0]     win_mask;
  logic [SCORE_W-1:0]   x_score;
  logic [SCORE_W-1:0]   o_score;
  logic                 disp_start;
  logic                 disp_win_x;
  logic                 disp_win_o;
  logic                 disp_tie;
  logic [2:0]           state;

  modport master (
    output start, cell_valid, cell_idx, restart, clear_scores,
    input  board_x, board_o, turn_x, move_ack, move_nack, busy, win_mask,
    input  x_score, o_score, disp_start, disp_win_x, disp_win_o, disp_tie, state
  );

  modport slave (
    input  start, cell_valid, cell_idx, restart, clear_scores,
    output board_x, board_o, turn_x, move_ack, move_nack, busy, win_mask,
    output x_score, o_score, disp_start, disp_win_x, disp_win_o, disp_tie, state
  );
endinterface

// File: rtl/game_core_nxn.sv
// rtl/game_core_nxn.sv - NxN tic-tac-toe engine: board, turn order, line-scan win/tie check, scores
module game_core_nxn #(
  parameter int N       = 3,
  parameter int SCORE_W = 4
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  game_core_nxn_if.slave  bus
);
  localparam int CELLS  = N * N;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int NLINES = 2 * N + 2;
  localparam int LINE_W = $clog2(NLINES);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN_X = 3'd3,
    S_WIN_O = 3'd4,
    S_TIE   = 3'd5
  } state_t;

  // Lines 0..N-1 rows, N..2N-1 columns, 2N main diagonal, 2N+1 anti-diagonal.
  function automatic logic [CELLS-1:0] line_mask(input int l);
    logic [CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (l < N)           m = m | (CELLS'(1) << (l * N + i));
      else if (l < 2 * N)  m = m | (CELLS'(1) << (i * N + (l - N)));
      else if (l == 2 * N) m = m | (CELLS'(1) << (i * (N + 1)));
      else                 m = m | (CELLS'(1) << ((i + 1) * (N - 1)));
    end
    return m;
  endfunction

  state_t              r_state;
  logic [LINE_W-1:0]   r_line;
  logic [CNT_W-1:0]    r_moves;
  logic [CELLS-1:0]    r_board_x;
  logic [CELLS-1:0]    r_board_o;
  logic [CELLS-1:0]    r_win_mask;
  logic                r_turn_x;
  logic                r_starter_x;
  logic                r_ack;
  logic                r_nack;
  logic [SCORE_W-1:0]  r_x_score;
  logic [SCORE_W-1:0]  r_o_score;

  logic [CELLS-1:0]    w_line_mask;
  logic [CELLS-1:0]    w_mover;
  logic [CELLS-1:0]    w_cell_bit;
  logic                w_line_full;
  logic                w_idx_ok;
  logic                w_occupied;
  logic                w_last_line;
  logic                w_board_full;
  logic                w_win;
  logic                w_x_inc;
  logic                w_o_inc;

  always_comb begin
    w_line_mask = '0;
    for (int l = 0; l < NLINES; l++) begin
      if (r_line == LINE_W'(l)) w_line_mask = line_mask(l);
    end
  end

  assign w_mover      = r_turn_x ? r_board_x : r_board_o;
  assign w_line_full  = ((w_mover & w_line_mask) == w_line_mask);
  assign w_idx_ok     = ({1'b0, bus.cell_idx} < (IDX_W + 1)'(CELLS));
  assign w_cell_bit   = CELLS'(1) << bus.cell_idx;
  assign w_occupied   = |((r_board_x | r_board_o) & w_cell_bit);
  assign w_last_line  = (r_line == LINE_W'(2 * N + 1));
  assign w_board_full = (r_moves == CNT_W'(CELLS));
  // A restart in CHECK aborts the scan, so it also suppresses the score bump.
  assign w_win        = (r_state == S_CHECK) && !bus.restart && w_line_full;
  assign w_x_inc      = w_win && r_turn_x;
  assign w_o_inc      = w_win && !r_turn_x;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state     <= S_START;
      r_line      <= '0;
      r_moves     <= '0;
      r_board_x   <= '0;
      r_board_o   <= '0;
      r_win_mask  <= '0;
      r_turn_x    <= 1'b1;
      r_starter_x <= 1'b1;
      r_ack       <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
      if (r_state == S_START) begin
        if (bus.start || bus.restart) begin
          r_state   <= S_PLAY;
          r_board_x <= '0;
          r_board_o <= '0;
        end
      end else if (bus.restart) begin
        r_state     <= S_PLAY;
        r_board_x   <= '0;
        r_board_o   <= '0;
        r_win_mask  <= '0;
        r_moves     <= '0;
        r_line      <= '0;
        r_starter_x <= !r_starter_x;
        r_turn_x    <= !r_starter_x;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (bus.cell_valid) begin
              if (!w_idx_ok || w_occupied) begin
                r_nack <= 1'b1;
              end else begin
                if (r_turn_x) r_board_x <= r_board_x | w_cell_bit;
                else          r_board_o <= r_board_o | w_cell_bit;
                r_moves <= r_moves + CNT_W'(1);
                r_ack   <= 1'b1;
                r_line  <= '0;
                r_state <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            r_nack <= bus.cell_valid;
            if (w_line_full) begin
              r_win_mask <= w_line_mask;
              r_state    <= r_turn_x ? S_WIN_X : S_WIN_O;
            end else if (w_last_line) begin
              if (w_board_full) begin
                r_state <= S_TIE;
              end else begin
                r_turn_x <= !r_turn_x;
                r_state  <= S_PLAY;
              end
            end else begin
              r_line <= r_line + LINE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_x_score <= '0;
      r_o_score <= '0;
    end else if (bus.clear_scores) begin
      r_x_score <= '0;
      r_o_score <= '0;
    end else begin
      if (w_x_inc && (r_x_score != {SCORE_W{1'b1}})) r_x_score <= r_x_score + SCORE_W'(1);
      if (w_o_inc && (r_o_score != {SCORE_W{1'b1}})) r_o_score <= r_o_score + SCORE_W'(1);
    end
  end

  assign bus.board_x    = r_board_x;
  assign bus.board_o    = r_board_o;
  assign bus.win_mask   = r_win_mask;
  assign bus.turn_x     = r_turn_x;
  assign bus.move_ack   = r_ack;
  assign bus.move_nack  = r_nack;
  assign bus.x_score    = r_x_score;
  assign bus.o_score    = r_o_score;
  assign bus.state      = r_state;
  assign bus.busy       = (r_state == S_CHECK);
  assign bus.disp_start = (r_state == S_START);
  assign bus.disp_win_x = (r_state == S_WIN_X);
  assign bus.disp_win_o = (r_state == S_WIN_O);
  assign bus.disp_tie   = (r_state == S_TIE);
endmodule

// File: tb/tb_game_core_nxn.sv
// tb/tb_game_core_nxn.sv - three engine instances (3x3, 5x5, 3x3 with 2-bit scores) against a game model
module tb_game_core_nxn;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      d_rst;
  logic [2:0]      d_start;
  logic [2:0]      d_cv;
  logic [2:0]      d_rs;
  logic [2:0]      d_cs;
  logic [2:0][6:0] d_ci;

  logic [2:0][63:0] o_bx, o_bo, o_wm;
  logic [2:0][7:0]  o_xs, o_os;
  logic [2:0][2:0]  o_st;
  logic [2:0]       o_turn, o_ack, o_nack, o_busy, o_ds, o_dwx, o_dwo, o_dt;

  game_core_nxn_if #(.N(3), .SCORE_W(4)) if0 ();
  game_core_nxn_if #(.N(5), .SCORE_W(4)) if1 ();
  game_core_nxn_if #(.N(3), .SCORE_W(2)) if2 ();

  game_core_nxn #(.N(3), .SCORE_W(4)) dut0 (.clk_100MHz(clk), .reset(d_rst[0]), .bus(if0));
  game_core_nxn #(.N(5), .SCORE_W(4)) dut1 (.clk_100MHz(clk), .reset(d_rst[1]), .bus(if1));
  game_core_nxn #(.N(3), .SCORE_W(2)) dut2 (.clk_100MHz(clk), .reset(d_rst[2]), .bus(if2));

  assign if0.start = d_start[0];  assign if0.cell_valid = d_cv[0];  assign if0.cell_idx = d_ci[0][3:0];
  assign if0.restart = d_rs[0];   assign if0.clear_scores = d_cs[0];
  assign if1.start = d_start[1];  assign if1.cell_valid = d_cv[1];  assign if1.cell_idx = d_ci[1][4:0];
  assign if1.restart = d_rs[1];   assign if1.clear_scores = d_cs[1];
  assign if2.start = d_start[2];  assign if2.cell_valid = d_cv[2];  assign if2.cell_idx = d_ci[2][3:0];
  assign if2.restart = d_rs[2];   assign if2.clear_scores = d_cs[2];

  assign o_bx[0] = 64'(if0.board_x);  assign o_bo[0] = 64'(if0.board_o);  assign o_wm[0] = 64'(if0.win_mask);
  assign o_bx[1] = 64'(if1.board_x);  assign o_bo[1] = 64'(if1.board_o);  assign o_wm[1] = 64'(if1.win_mask);
  assign o_bx[2] = 64'(if2.board_x);  assign o_bo[2] = 64'(if2.board_o);  assign o_wm[2] = 64'(if2.win_mask);
  assign o_xs[0] = 8'(if0.x_score);   assign o_os[0] = 8'(if0.o_score);   assign o_st[0] = if0.state;
  assign o_xs[1] = 8'(if1.x_score);   assign o_os[1] = 8'(if1.o_score);   assign o_st[1] = if1.state;
  assign o_xs[2] = 8'(if2.x_score);   assign o_os[2] = 8'(if2.o_score);   assign o_st[2] = if2.state;
  assign o_turn = {if2.turn_x, if1.turn_x, if0.turn_x};
  assign o_ack  = {if2.move_ack, if1.move_ack, if0.move_ack};
  assign o_nack = {if2.move_nack, if1.move_nack, if0.move_nack};
  assign o_busy = {if2.busy, if1.busy, if0.busy};
  assign o_ds   = {if2.disp_start, if1.disp_start, if0.disp_start};
  assign o_dwx  = {if2.disp_win_x, if1.disp_win_x, if0.disp_win_x};
  assign o_dwo  = {if2.disp_win_o, if1.disp_win_o, if0.disp_win_o};
  assign o_dt   = {if2.disp_tie, if1.disp_tie, if0.disp_tie};

  int n_checks = 0;
  int n_errors = 0;
  int last_busy = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Game model: states 0 START, 1 PLAY, 2 CHECK, 3 WIN_X, 4 WIN_O, 5 TIE.
  int          nn[3]   = '{3, 5, 3};
  int          smax[3] = '{15, 15, 3};
  int          m_st[3], m_moves[3], m_cd[3], m_pl[3], m_xs[3], m_os[3];
  logic [63:0] m_bx[3], m_bo[3], m_wm[3];
  bit          m_turn[3], m_starter[3], m_ack[3], m_nack[3];

  function automatic int cell_of(input int n, input int l, input int i);
    if (l < n)      return l * n + i;
    if (l < 2 * n)  return i * n + (l - n);
    if (l == 2 * n) return i * (n + 1);
    return (i + 1) * (n - 1);
  endfunction

  function automatic logic [63:0] line_bits(input int n, input int l);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[cell_of(n, l, i)] = 1'b1;
    return b;
  endfunction

  // First line, in scan order, that the mover's pieces fill completely; -1 if none.
  function automatic int first_win(input int n, input logic [63:0] mine);
    logic [63:0] lb;
    for (int l = 0; l < 2 * n + 2; l++) begin
      lb = line_bits(n, l);
      if ((mine & lb) == lb) return l;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_st[k] = 0; m_moves[k] = 0; m_cd[k] = 0; m_pl[k] = -1; m_xs[k] = 0; m_os[k] = 0;
    m_bx[k] = '0; m_bo[k] = '0; m_wm[k] = '0;
    m_turn[k] = 1'b1; m_starter[k] = 1'b1; m_ack[k] = 1'b0; m_nack[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    int n, cells, idx;
    bit inc_x, inc_o;
    n = nn[k]; cells = n * n; idx = int'(d_ci[k]);
    inc_x = 1'b0; inc_o = 1'b0;
    m_ack[k] = 1'b0; m_nack[k] = 1'b0;
    if (m_st[k] == 0) begin
      if (d_start[k] || d_rs[k]) begin
        m_st[k] = 1; m_bx[k] = '0; m_bo[k] = '0;
      end
    end else if (d_rs[k]) begin
      m_bx[k] = '0; m_bo[k] = '0; m_wm[k] = '0; m_moves[k] = 0;
      m_starter[k] = !m_starter[k]; m_turn[k] = m_starter[k]; m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (d_cv[k]) begin
        if (idx >= cells || m_bx[k][idx] || m_bo[k][idx]) begin
          m_nack[k] = 1'b1;
        end else begin
          if (m_turn[k]) m_bx[k][idx] = 1'b1; else m_bo[k][idx] = 1'b1;
          m_moves[k]++; m_ack[k] = 1'b1; m_st[k] = 2;
          m_pl[k] = first_win(n, m_turn[k] ? m_bx[k] : m_bo[k]);
          m_cd[k] = (m_pl[k] >= 0) ? m_pl[k] + 1 : 2 * n + 2;
        end
      end
    end else if (m_st[k] == 2) begin
      if (d_cv[k]) m_nack[k] = 1'b1;
      m_cd[k]--;
      if (m_cd[k] == 0) begin
        if (m_pl[k] >= 0) begin
          m_wm[k] = line_bits(n, m_pl[k]);
          if (m_turn[k]) begin m_st[k] = 3; inc_x = 1'b1; end
          else           begin m_st[k] = 4; inc_o = 1'b1; end
        end else if (m_moves[k] == cells) begin
          m_st[k] = 5;
        end else begin
          m_turn[k] = !m_turn[k]; m_st[k] = 1;
        end
      end
    end
    if (d_cs[k]) begin
      m_xs[k] = 0; m_os[k] = 0;
    end else begin
      if (inc_x && m_xs[k] < smax[k]) m_xs[k]++;
      if (inc_o && m_os[k] < smax[k]) m_os[k]++;
    end
  endtask

  task automatic compare_all(input int k);
    check($sformatf("d%0d_board_x", k), o_bx[k], m_bx[k]);
    check($sformatf("d%0d_board_o", k), o_bo[k], m_bo[k]);
    check($sformatf("d%0d_win_mask", k), o_wm[k], m_wm[k]);
    check($sformatf("d%0d_state", k), 64'(o_st[k]), 64'(m_st[k]));
    check($sformatf("d%0d_turn_x", k), 64'(o_turn[k]), 64'(m_turn[k]));
    check($sformatf("d%0d_ack", k), 64'(o_ack[k]), 64'(m_ack[k]));
    check($sformatf("d%0d_nack", k), 64'(o_nack[k]), 64'(m_nack[k]));
    check($sformatf("d%0d_busy", k), 64'(o_busy[k]), 64'(m_st[k] == 2));
    check($sformatf("d%0d_x_score", k), 64'(o_xs[k]), 64'(m_xs[k]));
    check($sformatf("d%0d_o_score", k), 64'(o_os[k]), 64'(m_os[k]));
    check($sformatf("d%0d_screens", k), {60'd0, o_ds[k], o_dwx[k], o_dwo[k], o_dt[k]},
          {60'd0, m_st[k] == 0, m_st[k] == 3, m_st[k] == 4, m_st[k] == 5});
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!d_rst[k]) model_reset(k); else model_step(k);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) compare_all(k);
    d_cv = '0; d_rs = '0; d_cs = '0; d_start = '0;
  endtask

  // Drive one move and wait (bounded) until the DUT leaves CHECK; last_busy counts CHECK cycles.
  task automatic move(input int k, input int idx);
    d_cv[k] = 1'b1; d_ci[k] = 7'(idx);
    tick();
    last_busy = 0;
    for (int g = 0; g < 40 && o_busy[k]; g++) begin
      last_busy++;
      tick();
    end
  endtask

  task automatic restart(input int k);
    d_rs[k] = 1'b1;
    tick();
  endtask

  // Plays a round that X wins on row 0 whoever starts; final X2 only if do_last.
  task automatic x_win_round(input int k, input bit do_last);
    if (!m_turn[k]) begin
      move(k, 3); move(k, 0); move(k, 4); move(k, 1); move(k, 6);
    end else begin
      move(k, 0); move(k, 3); move(k, 1); move(k, 4);
    end
    if (do_last) move(k, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d_rst = '0; d_start = '0; d_cv = '0; d_rs = '0; d_cs = '0; d_ci = '0;
    for (int k = 0; k < 3; k++) model_reset(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) compare_all(k);
    tick();
    d_rst = '1;
    tick();

    d_start = '1;
    tick();
    check("start_state", 64'(o_st[0]), 64'd1);
    check("start_disp", 64'(o_ds[0]), 64'd0);
    check("start_turn", 64'(o_turn[0]), 64'd1);

    // 3x3 row-0 win for X
    move(0, 0); move(0, 3); move(0, 1); move(0, 4); move(0, 2);
    check("row_win_busy_cycles", 64'(last_busy), 64'd1);
    check("row_win_disp", 64'(o_dwx[0]), 64'd1);
    check("row_win_mask", o_wm[0], 64'h7);
    check("row_win_score", 64'(o_xs[0]), 64'd1);
    move(0, 5);
    check("win_hold_ack", 64'(o_ack[0] | o_nack[0]), 64'd0);

    // Illegal moves on a fresh 3x3
    move(2, 0);
    move(2, 0);
    check("nack_occupied", 64'(o_nack[2]), 64'd1);
    move(2, 9);
    check("nack_range", 64'(o_nack[2]), 64'd1);
    check("nack_turn", 64'(o_turn[2]), 64'd0);
    check("nack_board", o_bx[2] | (o_bo[2] << 32), 64'h1);

    // Tie with X starting
    restart(0); restart(0);
    move(0, 0); move(0, 1); move(0, 2); move(0, 4); move(0, 3);
    move(0, 5); move(0, 7); move(0, 6); move(0, 8);
    check("tie_busy_cycles", 64'(last_busy), 64'd8);
    check("tie_disp", 64'(o_dt[0]), 64'd1);
    check("tie_scores", {o_xs[0], o_os[0]}, 64'h0100);
    restart(0);
    check("tie_restart_turn", 64'(o_turn[0]), 64'd0);
    check("tie_restart_board", o_bx[0] | o_bo[0], 64'd0);

    // 5x5 anti-diagonal win
    move(1, 4); move(1, 0); move(1, 8); move(1, 1); move(1, 12);
    move(1, 2); move(1, 16); move(1, 3); move(1, 20);
    check("anti_busy_cycles", 64'(last_busy), 64'd12);
    check("anti_state", 64'(o_st[1]), 64'd3);
    check("anti_mask", o_wm[1], 64'h111110);

    // 2-bit score saturation
    restart(2);
    for (int r = 0; r < 5; r++) begin
      x_win_round(2, 1'b1);
      restart(2);
    end
    check("score_saturate", 64'(o_xs[2]), 64'd3);

    // clear_scores on the same edge as a win
    x_win_round(0, 1'b0);
    d_cv[0] = 1'b1; d_ci[0] = 7'd2;
    tick();
    d_cs[0] = 1'b1;
    tick();
    check("clear_on_win_disp", 64'(o_dwx[0]), 64'd1);
    check("clear_on_win_score", 64'(o_xs[0]), 64'd0);

    // Asynchronous reset mid-CHECK
    restart(1);
    d_cv[1] = 1'b1; d_ci[1] = 7'd7;
    tick(); tick(); tick();
    check("pre_reset_busy", 64'(o_busy[1]), 64'd1);
    #2 d_rst[1] = 1'b0;
    #1 model_reset(1);
    compare_all(1);
    check("async_reset_state", 64'(o_st[1]), 64'd0);
    check("async_reset_score", 64'(o_xs[1]), 64'd0);
    tick();
    d_rst[1] = 1'b1;
    tick();

    // Randomised play with coincident control inputs
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < 3; k++) begin
        d_cv[k]    = ($urandom_range(0, 99) < 45);
        d_ci[k]    = 7'($urandom_range(0, (k == 1) ? 31 : 15));
        d_rs[k]    = ($urandom_range(0, 99) < 3);
        d_cs[k]    = ($urandom_range(0, 99) < 2);
        d_start[k] = ($urandom_range(0, 99) < 10);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/game_core_nxn.md
# game_core_nxn

Parametrised game engine for the N×N tic-tac-toe family; successor to the fixed 3×3 finite-state machine in the TicTacToe top. Owns the board (one X bitmask and one O bitmask), turn order and move validation. Also runs a sequential line-scan win/tie checker, keeps saturating per-player scores and drives the one-hot screen selects consumed by the VGA painter. Sits between the mouse/cell-decode logic (move requests) and `VGAPainterColorConfig` (board, screens, winning line).

## Interface
- `N`, 3: board dimension, legal range 3..8; a win is N in a row, column or diagonal.
- `SCORE_W`, 4: width of each score counter.
- Derived: `CELLS = N*N`, `IDX_W = clog2(CELLS)`, `CNT_W = clog2(CELLS+1)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk_100MHz`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; forces every register to its reset value.
- `start`  in  1  leaves the START screen; one-cycle pulse.
- `cell_valid`  in  1  move request; one-cycle pulse.
- `cell_idx`  in  IDX_W  requested cell, row-major (`row*N + col`).
- `restart`  in  1  starts a new round and keeps the scores.
- `clear_scores`  in  1  zeroes both scores.
- `board_x`  out  CELLS  bit i set = X occupies cell i.
- `board_o`  out  CELLS  bit i set = O occupies cell i.
- `turn_x`  out  1  1 = X to move.
- `move_ack`  out  1  one-cycle pulse; move accepted.
- `move_nack`  out  1  one-cycle pulse; move rejected.
- `busy`  out  1  high while in CHECK.
- `win_mask`  out  CELLS  cells of the winning line; 0 unless in a WIN state.
- `x_score`, `o_score`  out  SCORE_W  saturating round-win counters.
- `disp_start`, `disp_win_x`, `disp_win_o`, `disp_tie`  out  1  screen selects; at most one is high.
- `state`  out  3  START=0, PLAY=1, CHECK=2, WIN_X=3, WIN_O=4, TIE=5.

## Operation
- Reset values: state START, `disp_start`=1, all other outputs 0 except `turn_x`=1, starter flag = X, move count 0.
- START: `start` or `restart` -> PLAY with an empty board; `cell_valid` is ignored.
- PLAY, when `cell_valid`=1:
  - If `cell_idx` >= CELLS or the cell is occupied: `move_nack`; no state change.
  - Otherwise: set the mover's bit, increment the move count, `move_ack`, and enter CHECK with line counter L=0.
- CHECK scans one line per cycle, for the player who just moved only:
  - L=0..N-1 are rows, L=N..2N-1 are columns, L=2N is the main diagonal (cells `i*(N+1)`), L=2N+1 is the anti-diagonal (cells `(i+1)*(N-1)`).
  - Line full for the mover: latch `win_mask`, increment that player's score, go to WIN_X or WIN_O.
  - L=2N+1 and no win: if move count = CELLS go to TIE; else toggle `turn_x` and return to PLAY.
  - `cell_valid` during CHECK -> `move_nack`.
- WIN_X, WIN_O, TIE: hold. Board, `win_mask` and the screen select stay stable; `cell_valid` is ignored.
- `restart` in PLAY, CHECK, WIN_* or TIE:
  - Clear the board, `win_mask`, the move count and L.
  - Toggle the starter flag; `turn_x` takes the new starter.
  - Go to PLAY.
- Scores saturate at 2^SCORE_W−1. `clear_scores` is honoured in every state.
- Priority when inputs coincide:
  - `restart` beats `cell_valid`: no ack or nack, and the move is not written.
  - `clear_scores` beats a same-cycle score increment: the score ends at 0.
  - `restart` in CHECK aborts the scan; no score changes.
- All outputs are registered; the screen selects decode the registered state.

## Timing
- Edge E0 samples `cell_valid`. After E0: the board bit is set, `move_ack`=1 for one cycle, state=CHECK, `busy`=1.
- A win on line L takes effect at edge E(L+1): the WIN state, the score and `win_mask` all update at that edge.
- Worst-case check latency is 2N+2 cycles: 8 for N=3, 18 for N=8. A no-win result (TIE, or back to PLAY with the turn toggled) lands at E(2N+2).
- `move_nack` is asserted in the cycle after the sampling edge.
- `restart` takes effect at the next edge.
- Reset is asynchronous: outputs change on assertion without waiting for a clock edge.

## Test plan
- Reset, then `start`: state=1, `turn_x`=1, both boards 0, `disp_start` falls 1 -> 0, scores 0.
- N=3, moves X0,O3,X1,O4,X2:
  - Last ack; one cycle later `disp_win_x`=1.
  - `win_mask`=9'b000000111, `x_score`=1.
  - A further `cell_valid` produces neither ack nor nack.
- N=3, X0 then X0 again (O's turn), then `cell_idx`=9: two `move_nack` pulses; `turn_x`=0 and the boards are unchanged.
- N=3 tie, moves X0,O1,X2,O4,X3,O5,X7,O6,X8:
  - `busy` is high 8 cycles after the last ack, then `disp_tie`=1.
  - Scores unchanged.
  - `restart` -> empty board, `turn_x`=0.
- N=5, X wins on the anti-diagonal (cells 4,8,12,16,20): the WIN_X state is entered exactly 12 cycles after the ack; `win_mask` has exactly those 5 bits.
- Boundary cases:
  - SCORE_W=2: X wins 5 rounds -> `x_score` stays 3.
  - `clear_scores` coincident with a win edge -> `x_score`=0.
  - `reset` low mid-CHECK -> immediate START with all reset values.
